// File: rtl/div_arbiter_if.sv
// Bundle of requester, result and shared-divider signals around div_arbiter.
// slave = the arbiter; master = the requesters plus divider that surround it.
interface div_arbiter_if;
    // Requests are level-held until the matching one-cycle ack; done/err pulse once per grant.
    logic        req0, req1;
    logic [15:0] a0, a1;
    logic [7:0]  b0, b1;
    logic        ack0, ack1;
    logic        done0, done1;
    logic        err0, err1;
    logic [15:0] q;
    logic [7:0]  rem;
    logic        div_ini;
    logic [15:0] div_a;
    logic [7:0]  div_b;
    logic        div_ocup;
    logic        div_p;
    logic [15:0] div_r;
    logic [7:0]  div_rem;

    modport slave (
        input  req0, req1, a0, a1, b0, b1, div_ocup, div_p, div_r, div_rem,
        output ack0, ack1, done0, done1, err0, err1, q, rem, div_ini, div_a, div_b
    );

    modport master (
        output req0, req1, a0, a1, b0, b1, div_ocup, div_p, div_r, div_rem,
        input  ack0, ack1, done0, done1, err0, err1, q, rem, div_ini, div_a, div_b
    );
endinterface

// File: rtl/div_arbiter.sv
// Round-robin arbiter sharing one divider between two requesters, with
// divide-by-zero short-cut and a WAIT timeout that reports an error result.
module div_arbiter #(
    parameter logic [17:0] TO_CYC = 18'd140000
) (
    input  logic         clk,
    input  logic         reset,
    div_arbiter_if.slave bus,
    output logic [1:0]   dbg_state
);
    typedef enum logic [1:0] {IDLE = 2'd0, ISSUE = 2'd1, WAIT = 2'd2, CAPT = 2'd3} state_t;

    state_t      state, state_n;
    logic [15:0] op_a, op_a_n;
    logic [7:0]  op_b, op_b_n;
    logic        owner, owner_n;
    logic        last_gnt, last_gnt_n;
    logic        zero_div, zero_div_n;
    logic [17:0] cnt, cnt_n;
    logic        ack0, ack1, ack0_n, ack1_n;
    logic        done0, done1, done0_n, done1_n;
    logic        err0, err1, err0_n, err1_n;
    logic        ini, ini_n;
    logic [15:0] q, q_n;
    logic [7:0]  rem, rem_n;
    logic        gnt, fin, fin_err;

    // last_gnt resets to 1 so requester 0 wins the first simultaneous contest.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            op_a     <= '0;
            op_b     <= '0;
            owner    <= 1'b0;
            last_gnt <= 1'b1;
            zero_div <= 1'b0;
            cnt      <= '0;
            ack0     <= 1'b0;
            ack1     <= 1'b0;
            done0    <= 1'b0;
            done1    <= 1'b0;
            err0     <= 1'b0;
            err1     <= 1'b0;
            ini      <= 1'b0;
            q        <= '0;
            rem      <= '0;
        end else begin
            state    <= state_n;
            op_a     <= op_a_n;
            op_b     <= op_b_n;
            owner    <= owner_n;
            last_gnt <= last_gnt_n;
            zero_div <= zero_div_n;
            cnt      <= cnt_n;
            ack0     <= ack0_n;
            ack1     <= ack1_n;
            done0    <= done0_n;
            done1    <= done1_n;
            err0     <= err0_n;
            err1     <= err1_n;
            ini      <= ini_n;
            q        <= q_n;
            rem      <= rem_n;
        end
    end

    always_comb begin
        state_n    = state;
        op_a_n     = op_a;
        op_b_n     = op_b;
        owner_n    = owner;
        last_gnt_n = last_gnt;
        zero_div_n = zero_div;
        cnt_n      = cnt;
        q_n        = q;
        rem_n      = rem;
        ack0_n     = 1'b0;
        ack1_n     = 1'b0;
        ini_n      = 1'b0;
        gnt        = 1'b0;
        fin        = 1'b0;
        fin_err    = 1'b0;

        case (state)
            IDLE: begin
                if (bus.req0 | bus.req1) begin
                    gnt        = (bus.req0 & bus.req1) ? ~last_gnt : bus.req1;
                    owner_n    = gnt;
                    last_gnt_n = gnt;
                    op_a_n     = gnt ? bus.a1 : bus.a0;
                    op_b_n     = gnt ? bus.b1 : bus.b0;
                    ack0_n     = ~gnt;
                    ack1_n     = gnt;
                    zero_div_n = (op_b_n == 8'd0);
                    // A zero divisor never reaches the divider; CAPT forms the error result.
                    state_n    = zero_div_n ? CAPT : ISSUE;
                end
            end
            ISSUE: begin
                if (!bus.div_ocup && !bus.div_p) begin
                    ini_n   = 1'b1;
                    cnt_n   = '0;
                    state_n = WAIT;
                end
            end
            WAIT: begin
                if (bus.div_p) begin
                    state_n = CAPT;
                end else begin
                    cnt_n = (cnt == 18'h3FFFF) ? cnt : cnt + 18'd1;
                    if (({1'b0, cnt} + 19'd1) >= {1'b0, TO_CYC}) begin
                        fin     = 1'b1;
                        fin_err = 1'b1;
                        q_n     = 16'hFFFF;
                        rem_n   = 8'hFF;
                        state_n = IDLE;
                    end
                end
            end
            CAPT: begin
                fin     = 1'b1;
                state_n = IDLE;
                if (zero_div) begin
                    fin_err = 1'b1;
                    q_n     = 16'hFFFF;
                    rem_n   = op_a[7:0];
                end else begin
                    q_n     = bus.div_r;
                    rem_n   = bus.div_rem;
                end
            end
            default: state_n = IDLE;
        endcase

        done0_n = fin & ~owner;
        done1_n = fin & owner;
        err0_n  = fin_err & ~owner;
        err1_n  = fin_err & owner;
    end

    assign bus.ack0    = ack0;
    assign bus.ack1    = ack1;
    assign bus.done0   = done0;
    assign bus.done1   = done1;
    assign bus.err0    = err0;
    assign bus.err1    = err1;
    assign bus.q       = q;
    assign bus.rem     = rem;
    assign bus.div_ini = ini;
    // Operand registers double as the divider operand bus, stable from ISSUE through CAPT.
    assign bus.div_a   = op_a;
    assign bus.div_b   = op_b;
    assign dbg_state   = state;
endmodule

// File: tb/tb_div_arbiter.sv
// Directed bench for div_arbiter: two requesters, a small divider model and a
// result scoreboard checked as the arbiter reports done.
module tb_div_arbiter;
    localparam logic [17:0] TO = 18'd20;

    logic       clk = 1'b0;
    logic       reset;
    logic [1:0] dbg_state;

    div_arbiter_if bus ();

    div_arbiter #(.TO_CYC(TO)) dut (
        .clk       (clk),
        .reset     (reset),
        .bus       (bus),
        .dbg_state (dbg_state)
    );

    always #5 clk = ~clk;

    logic [25:0] exp_q[$];
    logic        gnt_q[$];
    int          vectors = 0;
    int          miscompares = 0;
    int          cyc = 0;
    int          ini_cnt = 0;
    int          last_ini_cyc = 0;
    int          last_ack_cyc = 0;
    int          last_done_cyc = -10;
    int          b2b_grants = 0;
    logic        stuck_mode = 1'b0;
    logic        release_stuck = 1'b0;
    logic        manual_ocup = 1'b0;
    logic        stuck_busy = 1'b0;
    logic        m_busy = 1'b0;
    int          m_cnt = 0;
    logic [15:0] m_a = '0;
    logic [15:0] m_b = 16'd1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [25:0] model(input logic ch, input logic [15:0] a,
                                          input logic [7:0] b, input logic timeout);
        logic [15:0] bq;
        bq = {8'd0, b};
        if (b == 8'd0) return {ch, 1'b1, 16'hFFFF, a[7:0]};
        if (timeout)   return {ch, 1'b1, 16'hFFFF, 8'hFF};
        return {ch, 1'b0, a / bq, 8'(a % bq)};
    endfunction

    // One clock step: monitor outputs, advance the divider model, drop acked requests.
    task automatic tick();
        logic [15:0] tmp;
        @(negedge clk);
        cyc++;
        if (!reset) begin
            if (bus.ack0 | bus.ack1) begin
                chk("ack_onehot", 32'(bus.ack0 & bus.ack1), 32'd0);
                if (gnt_q.size() == 0) chk("ack_expected", 32'(gnt_q.size()), 32'd1);
                else chk("grant_owner", 32'(bus.ack1), 32'(gnt_q.pop_front()));
                if (cyc == last_done_cyc + 1) b2b_grants++;
                last_ack_cyc = cyc;
            end
            if (bus.done0 | bus.done1) begin
                chk("done_onehot", 32'(bus.done0 & bus.done1), 32'd0);
                if (exp_q.size() == 0) chk("done_expected", 32'(exp_q.size()), 32'd1);
                else chk("result", 32'({bus.done1, (bus.done1 ? bus.err1 : bus.err0), bus.q, bus.rem}),
                         32'(exp_q.pop_front()));
                last_done_cyc = cyc;
            end
            if ((bus.err0 & ~bus.done0) | (bus.err1 & ~bus.done1))
                chk("err_without_done", {30'd0, bus.err1, bus.err0}, {30'd0, bus.done1, bus.done0});
            if (bus.div_ini) begin
                ini_cnt++;
                last_ini_cyc = cyc;
            end
        end
        if (reset) begin
            m_busy     = 1'b0;
            stuck_busy = 1'b0;
            bus.div_p  = 1'b0;
        end else begin
            if (release_stuck) stuck_busy = 1'b0;
            if (bus.div_p) begin
                bus.div_p   = 1'b0;
                bus.div_r   = m_a / m_b;
                tmp         = m_a % m_b;
                bus.div_rem = tmp[7:0];
            end
            if (bus.div_ini) begin
                if (stuck_mode) stuck_busy = 1'b1;
                else begin
                    m_busy = 1'b1;
                    m_cnt  = 3;
                    m_a    = bus.div_a;
                    m_b    = {8'd0, bus.div_b};
                end
            end else if (m_busy) begin
                m_cnt--;
                if (m_cnt == 0) begin
                    m_busy    = 1'b0;
                    bus.div_p = 1'b1;
                end
            end
        end
        bus.div_ocup = m_busy | stuck_busy | manual_ocup;
        if (bus.ack0) bus.req0 = 1'b0;
        if (bus.ack1) bus.req1 = 1'b0;
    endtask

    task automatic push(input logic ch, input logic [15:0] a, input logic [7:0] b, input logic timeout);
        exp_q.push_back(model(ch, a, b, timeout));
        gnt_q.push_back(ch);
    endtask

    task automatic raise(input logic ch, input logic [15:0] a, input logic [7:0] b);
        if (ch) begin
            bus.a1 = a; bus.b1 = b; bus.req1 = 1'b1;
        end else begin
            bus.a0 = a; bus.b0 = b; bus.req0 = 1'b1;
        end
    endtask

    task automatic wait_ack(input logic ch, input int budget);
        int n = 0;
        while (!(ch ? bus.ack1 : bus.ack0) && n < budget) begin
            tick();
            n++;
        end
        chk("ack_seen", 32'(ch ? bus.ack1 : bus.ack0), 32'd1);
    endtask

    task automatic drain(input int budget);
        int n = 0;
        while ((exp_q.size() != 0 || gnt_q.size() != 0) && n < budget) begin
            tick();
            n++;
        end
        chk("drain_pending", 32'(exp_q.size() + gnt_q.size()), 32'd0);
        tick();
    endtask

    task automatic pulse_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        tick();
    endtask

    initial begin
        int ini0;
        int rel;
        int n;
        bus.req0 = 1'b0; bus.req1 = 1'b0;
        bus.a0 = '0; bus.a1 = '0; bus.b0 = '0; bus.b1 = '0;
        bus.div_ocup = 1'b0; bus.div_p = 1'b0; bus.div_r = '0; bus.div_rem = '0;
        reset = 1'b1;
        repeat (3) tick();

        // Reset state
        chk("rst_ack",   32'({bus.ack1, bus.ack0}), 32'd0);
        chk("rst_done",  32'({bus.done1, bus.done0}), 32'd0);
        chk("rst_err",   32'({bus.err1, bus.err0}), 32'd0);
        chk("rst_ini",   32'(bus.div_ini), 32'd0);
        chk("rst_q",     32'(bus.q), 32'd0);
        chk("rst_rem",   32'(bus.rem), 32'd0);
        chk("rst_div_a", 32'(bus.div_a), 32'd0);
        chk("rst_div_b", 32'(bus.div_b), 32'd0);
        chk("rst_state", 32'(dbg_state), 32'd0);
        reset = 1'b0;
        tick();

        // Single request through the divider: 100/7
        ini0 = ini_cnt;
        push(1'b0, 16'd100, 8'd7, 1'b0);
        raise(1'b0, 16'd100, 8'd7);
        drain(60);
        chk("single_ini", 32'(ini_cnt - ini0), 32'd1);

        // Simultaneous contest after reset, req0 re-requests while req1 waits
        pulse_reset();
        b2b_grants = 0;
        push(1'b0, 16'd20, 8'd6, 1'b0);
        push(1'b1, 16'd50, 8'd5, 1'b0);
        push(1'b0, 16'd33, 8'd4, 1'b0);
        raise(1'b0, 16'd20, 8'd6);
        raise(1'b1, 16'd50, 8'd5);
        wait_ack(1'b0, 10);
        tick();
        raise(1'b0, 16'd33, 8'd4);
        drain(150);
        chk("grant_after_done", 32'(b2b_grants), 32'd2);

        // Divide by zero: 300/0
        ini0 = ini_cnt;
        push(1'b1, 16'd300, 8'd0, 1'b0);
        raise(1'b1, 16'd300, 8'd0);
        drain(40);
        chk("zero_div_no_ini", 32'(ini_cnt - ini0), 32'd0);
        chk("zero_div_latency", 32'(last_done_cyc - last_ack_cyc), 32'd1);

        // Timeout with a divider that never finishes, then a request behind the busy divider
        stuck_mode = 1'b1;
        push(1'b0, 16'd1000, 8'd3, 1'b1);
        raise(1'b0, 16'd1000, 8'd3);
        drain(80);
        chk("timeout_latency", 32'(last_done_cyc - last_ini_cyc), 32'd20);
        push(1'b1, 16'd9, 8'd3, 1'b0);
        raise(1'b1, 16'd9, 8'd3);
        wait_ack(1'b1, 10);
        ini0 = ini_cnt;
        repeat (6) tick();
        chk("ini_held_after_timeout", 32'(ini_cnt - ini0), 32'd0);
        stuck_mode = 1'b0;
        release_stuck = 1'b1;
        tick();
        release_stuck = 1'b0;
        rel = cyc;
        drain(60);
        chk("ini_after_release", 32'(last_ini_cyc - rel), 32'd1);

        // div_ocup held high for 5 cycles in ISSUE: 77/10
        manual_ocup = 1'b1;
        push(1'b0, 16'd77, 8'd10, 1'b0);
        raise(1'b0, 16'd77, 8'd10);
        wait_ack(1'b0, 10);
        ini0 = ini_cnt;
        repeat (5) tick();
        chk("ini_held_while_ocup", 32'(ini_cnt - ini0), 32'd0);
        manual_ocup = 1'b0;
        tick();
        rel = cyc;
        tick();
        chk("ini_first_cycle", 32'(bus.div_ini), 32'd1);
        drain(60);
        chk("ini_after_ocup_fall", 32'(last_ini_cyc - rel), 32'd1);
        chk("ocup_single_ini", 32'(ini_cnt - ini0), 32'd1);

        // Reset during WAIT abandons the transaction
        gnt_q.push_back(1'b0);
        raise(1'b0, 16'd500, 8'd7);
        n = 0;
        while (!bus.div_ini && n < 40) begin
            tick();
            n++;
        end
        chk("wait_ini_seen", 32'(bus.div_ini), 32'd1);
        tick();
        chk("in_wait", 32'(dbg_state), 32'd2);
        reset = 1'b1;
        #1;
        chk("mid_rst_ack",   32'({bus.ack1, bus.ack0}), 32'd0);
        chk("mid_rst_done",  32'({bus.done1, bus.done0, bus.err1, bus.err0}), 32'd0);
        chk("mid_rst_ini",   32'(bus.div_ini), 32'd0);
        chk("mid_rst_q",     32'({bus.q, bus.rem}), 32'd0);
        chk("mid_rst_div",   32'({bus.div_a, bus.div_b}), 32'd0);
        chk("mid_rst_state", 32'(dbg_state), 32'd0);
        repeat (2) tick();
        reset = 1'b0;
        repeat (4) tick();
        chk("no_done_after_abandon", 32'(exp_q.size()), 32'd0);
        push(1'b0, 16'd9, 8'd3, 1'b0);
        raise(1'b0, 16'd9, 8'd3);
        drain(60);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
